// File: rtl/dac_seq_pkg.sv
// Shared types and sizing helpers for the DAC sequencer and its segment encoder.
package dac_seq_pkg;

   typedef enum logic [1:0] {
      StOff,
      StPwrup,
      StCal,
      StRun
   } seq_state_e;

   localparam int unsigned CODE_W_DEF = 10;
   localparam int unsigned BIN_W_DEF  = 7;
   localparam int unsigned UFLOW_W    = 16;

   function automatic int unsigned therm_w(input int unsigned code_w, input int unsigned bin_w);
      return (32'd1 << (code_w - bin_w)) - 32'd1;
   endfunction

   // Width of a pointer addressing 0..n-1 thermometer cells.
   function automatic int unsigned ptr_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dac_seg_encoder.sv
// Combinational split of a DAC code into binary LSB and thermometer MSB fields.
// With DAC_SEQ_DWA_EN defined the thermometer cells are rotated by ptr.
module dac_seg_encoder
   import dac_seq_pkg::*;
#(
   parameter int unsigned CODE_W  = CODE_W_DEF,
   parameter int unsigned BIN_W   = BIN_W_DEF,
   localparam int unsigned THERM_W = therm_w(CODE_W, BIN_W)
) (
   input  logic [CODE_W-1:0]            code,
`ifdef DAC_SEQ_DWA_EN
   input  logic [ptr_w(THERM_W)-1:0]    ptr,
`endif
   output logic [BIN_W-1:0]             bin,
   output logic [THERM_W-1:0]           therm
);

   localparam int unsigned MSB_W = CODE_W - BIN_W;

   logic [MSB_W-1:0]   msb;
   logic [THERM_W-1:0] base;

   assign msb = code[CODE_W-1:BIN_W];
   assign bin = code[BIN_W-1:0];

   always_comb begin
      base = '0;
      for (int unsigned i = 0; i < THERM_W; i++) begin
         base[i] = (32'(msb) > i);
      end
   end

`ifdef DAC_SEQ_DWA_EN
   // Rotate left by ptr: the upper half of the doubled pattern is the wrapped result.
   logic [2*THERM_W-1:0] rot;
   assign rot   = {base, base} << ptr;
   assign therm = rot[2*THERM_W-1:THERM_W];
`else
   assign therm = base;
`endif

endmodule

// File: rtl/dac_seq_ctrl.sv
// Power-up/calibration sequencer and rate-paced sample streamer for the segmented DAC.
// Optional data-weighted averaging of the thermometer field under DAC_SEQ_DWA_EN.
module dac_seq_ctrl
   import dac_seq_pkg::*;
#(
   parameter int unsigned CODE_W    = CODE_W_DEF,
   parameter int unsigned BIN_W     = BIN_W_DEF,
   parameter int unsigned PWRUP_CYC = 64,
   parameter int unsigned CAL_CYC   = 256,
   parameter int unsigned DIV_W     = 16,
   parameter int unsigned ATB_N     = 10,
   localparam int unsigned THERM_W  = therm_w(CODE_W, BIN_W)
) (
   input  logic                clkin,
   input  logic                rst,
   input  logic                enable,
   input  logic                ramp_mode,
   input  logic [DIV_W-1:0]    rate_div,
   input  logic                s_valid,
   input  logic [CODE_W-1:0]   s_code,
   output logic                s_ready,
   input  logic [3:0]          atb_sel,
   output logic                pdb,
   output logic                cal_en,
   output logic [BIN_W-1:0]    datainbin,
   output logic [BIN_W-1:0]    datainbinb,
   output logic [THERM_W-1:0]  dataintherm,
   output logic [THERM_W-1:0]  datainthermb,
   output logic [ATB_N-1:0]    atb_ena,
   output logic                busy,
   output logic [UFLOW_W-1:0]  underflow_cnt
);

   localparam int unsigned CNT_MAX = (PWRUP_CYC > CAL_CYC) ? PWRUP_CYC : CAL_CYC;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

   seq_state_e          state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [DIV_W-1:0]    div_q;
   logic [CODE_W-1:0]   ramp_q;

   logic [DIV_W-1:0]    term_m1;
   logic                strobe;
   logic                load;
   logic [CODE_W-1:0]   sel_code;
   logic [BIN_W-1:0]    enc_bin;
   logic [THERM_W-1:0]  enc_therm;
   logic [ATB_N-1:0]    atb_dec;

   // A rate of 0 behaves as 1; >= compare lets a shrinking period strobe at once.
   assign term_m1  = (rate_div == '0) ? '0 : rate_div - DIV_W'(1);
   assign strobe   = (state_q == StRun) && (div_q >= term_m1);
   assign s_ready  = strobe && enable && !ramp_mode;
   assign sel_code = ramp_mode ? ramp_q : s_code;
   assign load     = strobe && (ramp_mode || s_valid);

   always_comb begin
      atb_dec = '0;
      for (int unsigned i = 0; i < ATB_N; i++) begin
         atb_dec[i] = (32'(atb_sel) == i);
      end
   end

`ifdef DAC_SEQ_DWA_EN
   localparam int unsigned PTR_W = ptr_w(THERM_W);

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;
   int unsigned      ptr_sum;

   always_comb begin
      ptr_sum = 32'(ptr_q) + 32'(sel_code[CODE_W-1:BIN_W]);
      if (ptr_sum >= THERM_W) begin
         ptr_sum = ptr_sum - THERM_W;
      end
      ptr_d = PTR_W'(ptr_sum);
   end
`endif

   dac_seg_encoder #(
      .CODE_W (CODE_W),
      .BIN_W  (BIN_W)
   ) u_enc (
      .code  (sel_code),
`ifdef DAC_SEQ_DWA_EN
      .ptr   (ptr_q),
`endif
      .bin   (enc_bin),
      .therm (enc_therm)
   );

   always_ff @(posedge clkin) begin
      if (rst) begin
         state_q       <= StOff;
         cnt_q         <= '0;
         div_q         <= '0;
         ramp_q        <= '0;
         pdb           <= 1'b0;
         cal_en        <= 1'b0;
         busy          <= 1'b0;
         datainbin     <= '0;
         datainbinb    <= '1;
         dataintherm   <= '0;
         datainthermb  <= '1;
         atb_ena       <= '0;
         underflow_cnt <= '0;
`ifdef DAC_SEQ_DWA_EN
         ptr_q         <= '0;
`endif
      end else if ((state_q != StOff) && !enable) begin
         // Shutdown: everything back to idle except the underflow history.
         state_q      <= StOff;
         cnt_q        <= '0;
         div_q        <= '0;
         ramp_q       <= '0;
         pdb          <= 1'b0;
         cal_en       <= 1'b0;
         busy         <= 1'b0;
         datainbin    <= '0;
         datainbinb   <= '1;
         dataintherm  <= '0;
         datainthermb <= '1;
         atb_ena      <= '0;
`ifdef DAC_SEQ_DWA_EN
         ptr_q        <= '0;
`endif
      end else begin
         unique case (state_q)
            StOff: begin
               if (enable) begin
                  state_q <= StPwrup;
                  cnt_q   <= '0;
                  pdb     <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            StPwrup: begin
               if (cnt_q == CNT_W'(PWRUP_CYC - 1)) begin
                  state_q <= StCal;
                  cnt_q   <= '0;
                  cal_en  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            StCal: begin
               if (cnt_q == CNT_W'(CAL_CYC - 1)) begin
                  state_q <= StRun;
                  cnt_q   <= '0;
                  cal_en  <= 1'b0;
                  div_q   <= '0;
                  ramp_q  <= '0;
`ifdef DAC_SEQ_DWA_EN
                  ptr_q   <= '0;
`endif
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            StRun: begin
               div_q <= strobe ? '0 : div_q + DIV_W'(1);
               if (strobe) begin
                  atb_ena <= atb_dec;
               end
               if (load) begin
                  datainbin    <= enc_bin;
                  datainbinb   <= ~enc_bin;
                  dataintherm  <= enc_therm;
                  datainthermb <= ~enc_therm;
`ifdef DAC_SEQ_DWA_EN
                  ptr_q        <= ptr_d;
`endif
               end
               if (strobe && ramp_mode) begin
                  ramp_q <= ramp_q + CODE_W'(1);
               end
               if (strobe && !ramp_mode && !s_valid && (underflow_cnt != '1)) begin
                  underflow_cnt <= underflow_cnt + UFLOW_W'(1);
               end
            end
            default: state_q <= StOff;
         endcase
      end
   end

endmodule

// File: tb/tb_dac_seq_ctrl.sv
// Directed self-checking bench for dac_seq_ctrl (default build; DWA steps under DAC_SEQ_DWA_EN).
module tb_dac_seq_ctrl;

   localparam int unsigned CODE_W  = 10;
   localparam int unsigned BIN_W   = 7;
   localparam int unsigned THERM_W = 7;
   localparam int unsigned DIV_W   = 16;
   localparam int unsigned ATB_N   = 10;

   logic                clkin = 1'b0;
   logic                rst;
   logic                enable;
   logic                ramp_mode;
   logic [DIV_W-1:0]    rate_div;
   logic                s_valid;
   logic [CODE_W-1:0]   s_code;
   logic                s_ready;
   logic [3:0]          atb_sel;
   logic                pdb;
   logic                cal_en;
   logic [BIN_W-1:0]    datainbin;
   logic [BIN_W-1:0]    datainbinb;
   logic [THERM_W-1:0]  dataintherm;
   logic [THERM_W-1:0]  datainthermb;
   logic [ATB_N-1:0]    atb_ena;
   logic                busy;
   logic [15:0]         underflow_cnt;

   int total = 0;
   int bad   = 0;
   int gap;

   dac_seq_ctrl dut (
      .clkin         (clkin),
      .rst           (rst),
      .enable        (enable),
      .ramp_mode     (ramp_mode),
      .rate_div      (rate_div),
      .s_valid       (s_valid),
      .s_code        (s_code),
      .s_ready       (s_ready),
      .atb_sel       (atb_sel),
      .pdb           (pdb),
      .cal_en        (cal_en),
      .datainbin     (datainbin),
      .datainbinb    (datainbinb),
      .dataintherm   (dataintherm),
      .datainthermb  (datainthermb),
      .atb_ena       (atb_ena),
      .busy          (busy),
      .underflow_cnt (underflow_cnt)
   );

   always #5 clkin = ~clkin;

   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected {bin, therm} for a static thermometer mapping.
   function automatic logic [13:0] seg_of(input logic [9:0] code);
      logic [7:0] t;
      t = (8'd1 << code[9:7]) - 8'd1;
      return {code[6:0], t[6:0]};
   endfunction

   task automatic chk_seg(input string tag, input logic [9:0] code);
      logic [13:0] e;
      logic [13:0] e_n;
      e   = seg_of(code);
      e_n = ~e;
      chk(tag, 32'({datainbin, dataintherm}), 32'(e));
      chk({tag, "_cmpl"}, 32'({datainbinb, datainthermb}), 32'(e_n));
   endtask

   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (s_ready !== 1'b1 && cnt < 64) begin
         tick();
         cnt++;
      end
      chk("ready_seen", 32'(s_ready), 32'd1);
   endtask

   initial begin
      logic [9:0] codes [4];
      logic [13:0] rexp;
      codes = '{10'h000, 10'h07F, 10'h080, 10'h3FF};

      rst       = 1'b1;
      enable    = 1'b0;
      ramp_mode = 1'b0;
      rate_div  = 16'd4;
      s_valid   = 1'b1;
      s_code    = '0;
      atb_sel   = 4'd3;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Reset state
      chk("rst_ctl", 32'({pdb, cal_en, busy, s_ready}), 32'h0);
      chk_seg("rst_seg", 10'h000);
      chk("rst_atb", 32'(atb_ena), 32'h0);
      chk("rst_uf", 32'(underflow_cnt), 32'h0);

      // Power-up and calibration timing
      enable = 1'b1;
      tick();
      chk("pwrup_ctl", 32'({pdb, cal_en, busy}), 32'b101);
      repeat (63) tick();
      chk("cal_early", 32'(cal_en), 32'd0);
      tick();
      chk("cal_rise", 32'({pdb, cal_en}), 32'b11);
      repeat (255) tick();
      chk("cal_last", 32'(cal_en), 32'd1);
      tick();
      chk("cal_fall", 32'({pdb, cal_en, busy}), 32'b101);

      // Stream at rate_div=4
      for (int i = 0; i < 4; i++) begin
         s_code = codes[i];
         wait_ready(gap);
         chk("strobe_gap", 32'(gap), 32'd3);
         tick();
         chk_seg("stream", codes[i]);
      end
      chk("atb_sel3", 32'(atb_ena), 32'h008);

      // Underflow at rate_div=2; atb_sel out of range
      rate_div = 16'd2;
      s_valid  = 1'b0;
      atb_sel  = 4'd12;
      for (int i = 0; i < 3; i++) begin
         wait_ready(gap);
         tick();
      end
      chk("uf_gap", 32'(gap), 32'd1);
      chk("uf_cnt", 32'(underflow_cnt), 32'd3);
      chk_seg("uf_hold", 10'h3FF);
      chk("atb_sel12", 32'(atb_ena), 32'h0);

      // Ramp at rate_div=1: one code per cycle, wrapping after 1023
      ramp_mode = 1'b1;
      rate_div  = 16'd1;
      for (int i = 0; i <= 1024; i++) begin
         tick();
         rexp = seg_of(10'(i % 1024));
         chk("ramp", 32'({s_ready, datainbin, dataintherm}), 32'({1'b0, rexp}));
      end

      // Shutdown mid-RUN after code 0x2AA with atb_sel=3
      ramp_mode = 1'b0;
      rate_div  = 16'd4;
      s_valid   = 1'b1;
      s_code    = 10'h2AA;
      atb_sel   = 4'd3;
      wait_ready(gap);
      chk("run_gap", 32'(gap), 32'd3);
      tick();
`ifndef DAC_SEQ_DWA_EN
      chk_seg("code_2aa", 10'h2AA);
`endif
      chk("atb_run", 32'(atb_ena), 32'h008);
      s_code = 10'h155;
      wait_ready(gap);
      enable = 1'b0;
      #1;
      chk("sd_noready", 32'(s_ready), 32'd0);
      tick();
      chk("sd_ctl", 32'({pdb, cal_en, busy, s_ready}), 32'h0);
      chk_seg("sd_seg", 10'h000);
      chk("sd_atb", 32'(atb_ena), 32'h0);
      chk("sd_uf", 32'(underflow_cnt), 32'd3);

      // Power back up, then saturate the underflow counter
      rate_div = 16'd1;
      s_valid  = 1'b0;
      enable   = 1'b1;
      tick();
      repeat (320) tick();
      chk("rerun_ctl", 32'({pdb, cal_en, busy}), 32'b101);

`ifdef DAC_SEQ_DWA_EN
      rate_div = 16'd4;
      s_valid  = 1'b1;
      s_code   = 10'h180;
      wait_ready(gap);
      tick();
      chk("dwa0", 32'(dataintherm), 32'h07);
      wait_ready(gap);
      tick();
      chk("dwa1", 32'(dataintherm), 32'h38);
      wait_ready(gap);
      tick();
      // cells 6, 0, 1
      chk("dwa2", 32'(dataintherm), 32'h43);
      rate_div = 16'd1;
      s_valid  = 1'b0;
`endif

      repeat (65600) tick();
      chk("uf_sat", 32'(underflow_cnt), 32'hFFFF);

      // Reset mid-operation
      rst = 1'b1;
      tick();
      chk("rst2_ctl", 32'({pdb, cal_en, busy, s_ready}), 32'h0);
      chk("rst2_uf", 32'(underflow_cnt), 32'h0);
      chk_seg("rst2_seg", 10'h000);
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
